modulation_segment_8_serializer: RTL and testbench

Transmit-side counterpart of the segment demodulator. The block captures a frame of ten 32-bit segment words on `start` and serializes them, one word per accepted beat, onto a 32-bit `output_bit` stream. It uses a valid/ready handshake toward the downstream modulation pipe. It reports frame completion with the same `start`/`valid`/`busy` control style used across the modulation pipeline.

---
 rtl/modulation_segment_8_serializer_pkg.sv | 35 +++
 rtl/modulation_segment_8_serializer_frame_buffer.sv | 58 +++++
 rtl/modulation_segment_8_serializer.sv | 113 +++++++++++
 tb/tb_modulation_segment_8_serializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/modulation_segment_8_serializer_pkg.sv
// Shared types and constants for the segment serializer.
// The optional trailing checksum beat is enabled by defining MOD_CHECKSUM_EN.
package modulation_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SEG = 10;
  localparam int IDX_W   = $clog2(NUM_SEG + 1);

`ifdef MOD_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_SEG + 1;
`else
  localparam int FRAME_LEN = NUM_SEG;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NUM_SEG-1:0][DATA_W-1:0] seg_bus_t;

`ifdef MOD_CHECKSUM_EN
  function automatic word_t xor_fold(input seg_bus_t segs);
    word_t acc;
    acc = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      acc = acc ^ segs[i];
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/modulation_segment_8_serializer_frame_buffer.sv
// Ten-word hold buffer with an index-selected read port.
// With MOD_CHECKSUM_EN defined, index NUM_SEG reads the captured XOR checksum.
module modulation_frame_buffer
  import modulation_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  seg_bus_t          seg_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] rdata_o
);

  seg_bus_t hold_q;

  // Frame payload is snapshotted only on the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (capture_i) begin
      hold_q <= seg_i;
    end
  end

`ifdef MOD_CHECKSUM_EN
  word_t csum_q;

  // Checksum is folded from the same inputs that load the hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (capture_i) begin
      csum_q <= xor_fold(seg_i);
    end
  end

  // Read mux: payload words first, then the checksum beat.
  always_comb begin
    rdata_o = '0;
    if (idx_i < IDX_W'(NUM_SEG)) begin
      rdata_o = hold_q[idx_i];
    end else begin
      rdata_o = csum_q;
    end
  end
`else
  // Read mux over the payload words only.
  always_comb begin
    rdata_o = '0;
    if (idx_i < IDX_W'(NUM_SEG)) begin
      rdata_o = hold_q[idx_i];
    end else begin
      rdata_o = '0;
    end
  end
`endif

endmodule

// File: rtl/modulation_segment_8_serializer.sv
// Frame serializer: captures ten segment words on start and streams them over valid/ready.
// Define MOD_CHECKSUM_EN to append an XOR checksum beat to every frame.
module modulation_segment_8_serializer
  import modulation_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] segment_0,
  input  logic [DATA_W-1:0] segment_1,
  input  logic [DATA_W-1:0] segment_2,
  input  logic [DATA_W-1:0] segment_3,
  input  logic [DATA_W-1:0] segment_4,
  input  logic [DATA_W-1:0] segment_5,
  input  logic [DATA_W-1:0] segment_6,
  input  logic [DATA_W-1:0] segment_7,
  input  logic [DATA_W-1:0] segment_8,
  input  logic [DATA_W-1:0] segment_9,
  output logic [DATA_W-1:0] output_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              valid,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               capture_s;
  logic               beat_fire_s;
  logic               last_beat_s;
  logic [DATA_W-1:0]  rdata_s;
  seg_bus_t           segs_s;

  assign segs_s = {segment_9, segment_8, segment_7, segment_6, segment_5,
                   segment_4, segment_3, segment_2, segment_1, segment_0};

  assign capture_s   = (state_q == ST_IDLE) && start;
  assign beat_fire_s = (state_q == ST_SEND) && out_ready;
  assign last_beat_s = beat_fire_s && (index_q == IDX_W'(FRAME_LEN - 1));

  modulation_frame_buffer u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .capture_i (capture_s),
    .seg_i     (segs_s),
    .idx_i     (index_q),
    .rdata_o   (rdata_s)
  );

  // State and beat index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Next state: start is only looked at in IDLE and DONE, so a drop during SEND is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SEND;
        else       state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (last_beat_s) state_d = ST_DONE;
        else             state_d = ST_SEND;
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
        else        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat index advances only on accepted beats and is parked at zero between frames.
  always_comb begin
    index_d = index_q;
    if (capture_s || last_beat_s) begin
      index_d = '0;
    end else if (beat_fire_s) begin
      index_d = index_q + IDX_W'(1);
    end else begin
      index_d = index_q;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    out_valid  = 1'b0;
    busy       = 1'b0;
    valid      = 1'b0;
    output_bit = '0;
    case (state_q)
      ST_SEND: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        output_bit = rdata_s;
      end
      ST_DONE: valid = 1'b1;
      default: begin
        out_valid  = 1'b0;
        output_bit = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_modulation_segment_8_serializer.sv
// Self-checking bench: table-driven control sequence, directed corner cases and
// randomized frames checked against a queue-based model of the beat stream.
module tb_modulation_segment_8_serializer;

`ifdef MOD_CHECKSUM_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        out_ready;
  logic [31:0] seg [10];
  logic [31:0] output_bit;
  logic        out_valid;
  logic        valid;
  logic        busy;

  int total;
  int bad;

  logic [31:0] cur_segs [10];
  int          stall_cycles [16];

  typedef struct {
    logic        start;
    logic        ready;
    logic        ov;
    logic        bsy;
    logic        vld;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [$];

  modulation_segment_8_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .segment_0  (seg[0]),
    .segment_1  (seg[1]),
    .segment_2  (seg[2]),
    .segment_3  (seg[3]),
    .segment_4  (seg[4]),
    .segment_5  (seg[5]),
    .segment_6  (seg[6]),
    .segment_7  (seg[7]),
    .segment_8  (seg[8]),
    .segment_9  (seg[9]),
    .output_bit (output_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .valid      (valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic bsy,
                            input logic vld, input logic [31:0] data);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
    check({tag, ".valid"},     {31'd0, valid},     {31'd0, vld});
    check({tag, ".data"},      output_bit,         data);
  endtask

  // Model: the frame is the captured words (plus their XOR when enabled); each
  // accepted beat pops one word, each stalled cycle costs exactly one cycle.
  task automatic run_frame(input string tag, input bit overwrite, input bit drop_start);
    logic [31:0] exp_q [$];
    logic [31:0] x;
    int beat, stall, cycles, stalls_total;
    x = 32'd0;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(cur_segs[k]);
      x = x ^ cur_segs[k];
      seg[k] = cur_segs[k];
    end
`ifdef MOD_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    start = 1'b1;
    out_ready = 1'b1;
    step();
    if (overwrite) begin
      for (int k = 0; k < 10; k++) seg[k] = 32'hFFFF_FFFF;
    end
    if (drop_start) start = 1'b0;
    beat = 0; stall = 0; cycles = 0; stalls_total = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      check($sformatf("%s.beat%0d.out_valid", tag, beat), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s.beat%0d.data", tag, beat), output_bit, exp_q[0]);
      if (stall < stall_cycles[beat]) begin
        out_ready = 1'b0;
        stall++;
        stalls_total++;
        step();
      end else begin
        out_ready = 1'b1;
        step();
        void'(exp_q.pop_front());
        beat++;
        stall = 0;
      end
      cycles++;
    end
    check({tag, ".frame_cycles"}, cycles, FRAME_LEN + stalls_total);
    check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b1, 32'd0);
    start = 1'b0;
    step();
    check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    total = 0;
    bad = 0;
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) seg[k] = 32'd0;
    for (int k = 0; k < 16; k++) stall_cycles[k] = 0;

    #12;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    #10 reset = 1'b1;
    step();
    check_outs("idle_after_reset", 1'b0, 1'b0, 1'b0, 32'd0);

    // Control sequence table: basic frame, DONE hold, restart, stall with start dropped.
    x = 32'd0;
    for (int k = 0; k < 10; k++) begin
      seg[k] = 32'h1000_0000 + k;
      x = x ^ seg[k];
    end
    for (int k = 0; k < FRAME_LEN; k++) begin
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, (k < 10) ? 32'h1000_0000 + k : x});
    end
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0000});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0001});
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start;
      out_ready = tbl[i].ready;
      step();
      check_outs($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].bsy, tbl[i].vld, tbl[i].data);
    end

    // Reset during beat 5 of the frame that the table left at beat 1.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset.beat5", output_bit, 32'h1000_0005);
    #2 reset = 1'b0;
    #1;
    check_outs("reset_midframe", 1'b0, 1'b0, 1'b0, 32'd0);
    start = 1'b1;
    step();
    check_outs("reset_held", 1'b0, 1'b0, 1'b0, 32'd0);
    #3 reset = 1'b1;
    for (int k = 0; k < 10; k++) cur_segs[k] = 32'h1000_0000 + k;
    run_frame("after_reset", 1'b0, 1'b0);

    // Backpressure: two stall cycles before beats 3 and 7.
    stall_cycles[3] = 2;
    stall_cycles[7] = 2;
    run_frame("backpressure", 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) stall_cycles[k] = 0;

    run_frame("overwrite", 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) cur_segs[k] = k + 1;
    run_frame("checksum", 1'b0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 10; k++) cur_segs[k] = $urandom;
      for (int k = 0; k < 16; k++) stall_cycles[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
